// File: rtl/mouse_render_pkg.sv
// rtl/mouse_render_pkg.sv - register map, poll states and clamp helper for the cursor renderer
package mouse_render_pkg;

  // Mouse register file map
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_XLO    = 3'd1;
  localparam logic [2:0] REG_XHI    = 3'd2;
  localparam logic [2:0] REG_YLO    = 3'd3;
  localparam logic [2:0] REG_YHI    = 3'd4;

  // Button bit positions inside the status byte
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;

  // One state per mouse register, visited round-robin
  typedef enum logic [2:0] {
    P_STATUS = 3'd0,
    P_XLO    = 3'd1,
    P_XHI    = 3'd2,
    P_YLO    = 3'd3,
    P_YHI    = 3'd4
  } poll_state_t;

  // Unsigned clamp of a raw 16-bit mouse coordinate to the last legal cursor origin
  function automatic logic [15:0] clamp_coord(input logic [15:0] raw, input logic [15:0] lim);
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/mouse_reg_poller.sv
// rtl/mouse_reg_poller.sv - round-robin mouse register poller with clamped validated shadow set
module mouse_reg_poller
  import mouse_render_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int COORD_W     = 10,
  parameter int CURSOR_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [2:0]         o_reg_addr,
  input  logic [7:0]         i_reg_data,
  output logic [1:0]         o_val_status,
  output logic [COORD_W-1:0] o_val_x,
  output logic [COORD_W-1:0] o_val_y
);

  localparam logic [15:0] X_LIM = 16'(H_RES - CURSOR_SIZE);
  localparam logic [15:0] Y_LIM = 16'(V_RES - CURSOR_SIZE);

  poll_state_t r_state;
  poll_state_t w_next;

  logic [1:0]         r_sh_status;
  logic [7:0]         r_sh_xlo;
  logic [7:0]         r_sh_xhi;
  logic [7:0]         r_sh_ylo;
  logic [1:0]         r_val_status;
  logic [COORD_W-1:0] r_val_x;
  logic [COORD_W-1:0] r_val_y;
  logic [15:0]        w_x_raw;
  logic [15:0]        w_y_raw;

  // Y_HI is taken straight from the bus on the P_YHI edge, so the full pair is
  // assembled and validated in the same cycle it completes
  assign w_x_raw = {r_sh_xhi, r_sh_xlo};
  assign w_y_raw = {i_reg_data, r_sh_ylo};

  // Poll state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= P_STATUS;
    else     r_state <= w_next;
  end

  // Next poll state and the register select it drives
  always_comb begin
    w_next     = P_STATUS;
    o_reg_addr = REG_STATUS;
    case (r_state)
      P_STATUS: begin w_next = P_XLO;    o_reg_addr = REG_STATUS; end
      P_XLO:    begin w_next = P_XHI;    o_reg_addr = REG_XLO;    end
      P_XHI:    begin w_next = P_YLO;    o_reg_addr = REG_XHI;    end
      P_YLO:    begin w_next = P_YHI;    o_reg_addr = REG_YLO;    end
      P_YHI:    begin w_next = P_STATUS; o_reg_addr = REG_YHI;    end
      default:  begin w_next = P_STATUS; o_reg_addr = REG_STATUS; end
    endcase
  end

  // Capture each polled byte into its shadow slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_status <= '0;
      r_sh_xlo    <= '0;
      r_sh_xhi    <= '0;
      r_sh_ylo    <= '0;
    end else begin
      case (r_state)
        P_STATUS: r_sh_status <= i_reg_data[1:0];
        P_XLO:    r_sh_xlo    <= i_reg_data;
        P_XHI:    r_sh_xhi    <= i_reg_data;
        P_YLO:    r_sh_ylo    <= i_reg_data;
        default:  ;
      endcase
    end
  end

  // Publish a complete, clamped set only once the whole poll round has been read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val_status <= '0;
      r_val_x      <= '0;
      r_val_y      <= '0;
    end else if (r_state == P_YHI) begin
      r_val_status <= r_sh_status;
      r_val_x      <= COORD_W'(clamp_coord(w_x_raw, X_LIM));
      r_val_y      <= COORD_W'(clamp_coord(w_y_raw, Y_LIM));
    end
  end

  assign o_val_status = r_val_status;
  assign o_val_x      = r_val_x;
  assign o_val_y      = r_val_y;

endmodule

// File: rtl/mouse_cursor_renderer.sv
// rtl/mouse_cursor_renderer.sv - full-frame framebuffer writer with a per-frame committed mouse cursor
module mouse_cursor_renderer
  import mouse_render_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int COORD_W     = 10,
  parameter int PIX_W       = 3,
  parameter int CURSOR_SIZE = 4,
  parameter logic [PIX_W-1:0] COLOR_BG    = PIX_W'(0),
  parameter logic [PIX_W-1:0] COLOR_IDLE  = PIX_W'(6),
  parameter logic [PIX_W-1:0] COLOR_LEFT  = PIX_W'(3),
  parameter logic [PIX_W-1:0] COLOR_RIGHT = PIX_W'(5),
  parameter logic [PIX_W-1:0] COLOR_BOTH  = PIX_W'(7)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [2:0]         reg_addr,
  input  logic [7:0]         reg_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               frame_done,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y
);

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_RES - 1);
  localparam logic [COORD_W:0]   CUR_SPAN = (COORD_W+1)'(CURSOR_SIZE);

  logic [1:0]         w_val_status;
  logic [COORD_W-1:0] w_val_x;
  logic [COORD_W-1:0] w_val_y;

  logic               r_valid;
  logic               r_frame_done;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_cur_status;
  logic [COORD_W-1:0] r_cur_x;
  logic [COORD_W-1:0] r_cur_y;

  logic               w_accept;
  logic               w_line_end;
  logic               w_frame_end;
  logic               w_in_x;
  logic               w_in_y;
  logic [PIX_W-1:0]   w_cursor_color;

  mouse_reg_poller #(
    .H_RES       (H_RES),
    .V_RES       (V_RES),
    .COORD_W     (COORD_W),
    .CURSOR_SIZE (CURSOR_SIZE)
  ) u_poller (
    .clk          (clk),
    .rst          (rst),
    .o_reg_addr   (reg_addr),
    .i_reg_data   (reg_data),
    .o_val_status (w_val_status),
    .o_val_x      (w_val_x),
    .o_val_y      (w_val_y)
  );

  assign w_accept    = r_valid & wr_ready;
  assign w_line_end  = (r_x == X_LAST);
  assign w_frame_end = w_line_end && (r_y == Y_LAST);

  // Raster scan: the address counter walks alongside x/y so no multiplier is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
    end else begin
      r_valid      <= 1'b1;
      r_frame_done <= w_accept & w_frame_end;
      if (w_accept) begin
        if (w_frame_end) begin
          r_x    <= '0;
          r_y    <= '0;
          r_addr <= '0;
        end else if (w_line_end) begin
          r_x    <= '0;
          r_y    <= r_y + 1'b1;
          r_addr <= r_addr + 1'b1;
        end else begin
          r_x    <= r_x + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  // Commit the validated set as the last pixel leaves, so the cursor never tears mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_status <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
    end else if (w_accept && w_frame_end) begin
      r_cur_status <= w_val_status;
      r_cur_x      <= w_val_x;
      r_cur_y      <= w_val_y;
    end
  end

  // Cursor hit test and button colour, from registered state only
  always_comb begin
    w_in_x = ({1'b0, r_x} >= {1'b0, r_cur_x}) && ({1'b0, r_x} < ({1'b0, r_cur_x} + CUR_SPAN));
    w_in_y = ({1'b0, r_y} >= {1'b0, r_cur_y}) && ({1'b0, r_y} < ({1'b0, r_cur_y} + CUR_SPAN));
    w_cursor_color = COLOR_IDLE;
    case ({r_cur_status[BTN_RIGHT], r_cur_status[BTN_LEFT]})
      2'b01:   w_cursor_color = COLOR_LEFT;
      2'b10:   w_cursor_color = COLOR_RIGHT;
      2'b11:   w_cursor_color = COLOR_BOTH;
      default: w_cursor_color = COLOR_IDLE;
    endcase
    wr_data = (w_in_x && w_in_y) ? w_cursor_color : COLOR_BG;
  end

  assign wr_valid   = r_valid;
  assign wr_addr    = r_addr;
  assign frame_done = r_frame_done;
  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;

endmodule
